// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback arbiter.
package regfile_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned NUM_REGS       = 1 << DEF_ADDR_WIDTH;

  // Requester port indices into the slot/grant vectors
  localparam int unsigned ALU = 0;
  localparam int unsigned LD  = 1;

  // With two requesters the "other" port is simply the complement
  function automatic logic other_port(input logic p);
    return ~p;
  endfunction

endpackage

// File: rtl/wb_slot.sv
// One-entry writeback holding slot: a fill loads addr/data, a drain frees it.
// A fill in the same cycle as a drain keeps the slot occupied with the new entry.
module wb_slot
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  fill,
  input  logic                  drain,
  input  logic [ADDR_WIDTH-1:0] fill_addr,
  input  logic [DATA_WIDTH-1:0] fill_data,
  output logic                  slot_valid,
  output logic [ADDR_WIDTH-1:0] slot_addr,
  output logic [DATA_WIDTH-1:0] slot_data
);

  // Slot occupancy and payload storage
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      slot_valid <= 1'b0;
      slot_addr  <= '0;
      slot_data  <= '0;
    end else if (fill) begin
      slot_valid <= 1'b1;
      slot_addr  <= fill_addr;
      slot_data  <= fill_data;
    end else if (drain) begin
      slot_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between the ALU and load writeback
// paths. Oldest entry wins; entries filled on the same edge are split round-robin.
// pendingMask flags every register with a write still buffered or on the port.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                         clock,
  input  logic                         resetN,
  input  logic                         aluValid,
  output logic                         aluReady,
  input  logic [ADDR_WIDTH-1:0]        aluAddr,
  input  logic [DATA_WIDTH-1:0]        aluData,
  input  logic                         ldValid,
  output logic                         ldReady,
  input  logic [ADDR_WIDTH-1:0]        ldAddr,
  input  logic [DATA_WIDTH-1:0]        ldData,
  output logic                         isWrite,
  output logic [ADDR_WIDTH-1:0]        A3,
  output logic [DATA_WIDTH-1:0]        writeData,
  output logic [(1<<ADDR_WIDTH)-1:0]   pendingMask
);

  localparam int unsigned MASK_W = 1 << ADDR_WIDTH;

  logic [1:0]            slot_vld;
  logic [1:0]            fill;
  logic [1:0]            grant;
  logic [1:0]            keep;
  logic [1:0]            vld_nxt;
  logic [ADDR_WIDTH-1:0] slot_addr [2];
  logic [DATA_WIDTH-1:0] slot_data [2];

  logic rr_ptr;
  logic rr_nxt;
  logic older_vld;
  logic older_vld_nxt;
  logic older_port;
  logic older_port_nxt;
  logic sel;

  wb_slot #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu_slot (
    .clock      (clock),
    .resetN     (resetN),
    .fill       (fill[ALU]),
    .drain      (grant[ALU]),
    .fill_addr  (aluAddr),
    .fill_data  (aluData),
    .slot_valid (slot_vld[ALU]),
    .slot_addr  (slot_addr[ALU]),
    .slot_data  (slot_data[ALU])
  );

  wb_slot #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ld_slot (
    .clock      (clock),
    .resetN     (resetN),
    .fill       (fill[LD]),
    .drain      (grant[LD]),
    .fill_addr  (ldAddr),
    .fill_data  (ldData),
    .slot_valid (slot_vld[LD]),
    .slot_addr  (slot_addr[LD]),
    .slot_data  (slot_data[LD])
  );

  // Grant selection: single occupant wins; two occupants go oldest-first, ties by rr pointer
  always_comb begin
    grant  = '0;
    rr_nxt = rr_ptr;
    case (slot_vld)
      2'b01:   grant[ALU] = 1'b1;
      2'b10:   grant[LD]  = 1'b1;
      2'b11: begin
        if (older_vld) begin
          grant[older_port] = 1'b1;
        end else begin
          grant[rr_ptr] = 1'b1;
          rr_nxt        = other_port(rr_ptr);
        end
      end
      default: grant = '0;
    endcase
  end

  // Ready depends only on slot state so a slot can be drained and refilled together
  always_comb begin
    aluReady  = ~slot_vld[ALU] | grant[ALU];
    ldReady   = ~slot_vld[LD]  | grant[LD];
    fill[ALU] = aluValid & aluReady;
    fill[LD]  = ldValid  & ldReady;
  end

  // Age tracking: remember which slot is older whenever both will hold entries from different edges
  always_comb begin
    older_vld_nxt  = older_vld;
    older_port_nxt = older_port;
    keep           = slot_vld & ~grant;
    vld_nxt        = fill | keep;
    if (vld_nxt != 2'b11) begin
      older_vld_nxt = 1'b0;
    end else if (fill[ALU] && fill[LD]) begin
      older_vld_nxt = 1'b0;
    end else if (fill[ALU]) begin
      older_vld_nxt  = 1'b1;
      older_port_nxt = 1'(LD);
    end else if (fill[LD]) begin
      older_vld_nxt  = 1'b1;
      older_port_nxt = 1'(ALU);
    end
  end

  // Arbitration state registers
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      rr_ptr     <= 1'b0;
      older_vld  <= 1'b0;
      older_port <= 1'b0;
    end else begin
      rr_ptr     <= rr_nxt;
      older_vld  <= older_vld_nxt;
      older_port <= older_port_nxt;
    end
  end

  assign sel = grant[LD];

  // Register-file write port: copy the granted slot, otherwise drop the enable
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      isWrite   <= 1'b0;
      A3        <= '0;
      writeData <= '0;
    end else if (|grant) begin
      isWrite   <= 1'b1;
      A3        <= slot_addr[sel];
      writeData <= slot_data[sel];
    end else begin
      isWrite   <= 1'b0;
    end
  end

  // In-flight write mask from buffered slots and the registered write port
  always_comb begin
    pendingMask = '0;
    for (int unsigned r = 0; r < MASK_W; r++) begin
      pendingMask[r] = (slot_vld[ALU] && (slot_addr[ALU] == ADDR_WIDTH'(r))) ||
                       (slot_vld[LD]  && (slot_addr[LD]  == ADDR_WIDTH'(r))) ||
                       (isWrite       && (A3             == ADDR_WIDTH'(r)));
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: timestamp-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned NR = NUM_REGS;

  logic          clock = 1'b0;
  logic          resetN = 1'b0;
  logic          aluValid = 1'b0;
  logic [AW-1:0] aluAddr = '0;
  logic [DW-1:0] aluData = '0;
  logic          ldValid = 1'b0;
  logic [AW-1:0] ldAddr = '0;
  logic [DW-1:0] ldData = '0;
  logic          aluReady;
  logic          ldReady;
  logic          isWrite;
  logic [AW-1:0] A3;
  logic [DW-1:0] writeData;
  logic [NR-1:0] pendingMask;

  regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock       (clock),
    .resetN      (resetN),
    .aluValid    (aluValid),
    .aluReady    (aluReady),
    .aluAddr     (aluAddr),
    .aluData     (aluData),
    .ldValid     (ldValid),
    .ldReady     (ldReady),
    .ldAddr      (ldAddr),
    .ldData      (ldData),
    .isWrite     (isWrite),
    .A3          (A3),
    .writeData   (writeData),
    .pendingMask (pendingMask)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each port holds at most one entry stamped with its acceptance cycle
  bit          mv    [2];
  bit [AW-1:0] maddr [2];
  bit [DW-1:0] mdata [2];
  int          mtime [2];
  bit          mrr;
  bit          exp_we;
  bit [AW-1:0] exp_a3;
  bit [DW-1:0] exp_wd;
  int          cyc = 0;
  bit [DW-1:0] ref_rf [NR];
  logic [DW-1:0] dut_rf [NR];

  function automatic int pick();
    if (mv[0] && mv[1]) begin
      if (mtime[0] < mtime[1]) return 0;
      if (mtime[1] < mtime[0]) return 1;
      return int'(mrr);
    end
    if (mv[0]) return 0;
    if (mv[1]) return 1;
    return -1;
  endfunction

  always @(posedge clock or negedge resetN) begin : model
    int g;
    if (!resetN) begin
      mv[0] = 1'b0; mv[1] = 1'b0; mrr = 1'b0;
      exp_we = 1'b0; exp_a3 = '0; exp_wd = '0;
    end else begin
      g = pick();
      if (mv[0] && mv[1] && mtime[0] == mtime[1]) mrr = !mrr;
      if (exp_we) ref_rf[exp_a3] = exp_wd;
      if (g >= 0) begin
        exp_we = 1'b1; exp_a3 = maddr[g]; exp_wd = mdata[g]; mv[g] = 1'b0;
      end else begin
        exp_we = 1'b0;
      end
      if (aluValid && !mv[0]) begin
        mv[0] = 1'b1; maddr[0] = aluAddr; mdata[0] = aluData; mtime[0] = cyc;
      end
      if (ldValid && !mv[1]) begin
        mv[1] = 1'b1; maddr[1] = ldAddr; mdata[1] = ldData; mtime[1] = cyc;
      end
      cyc++;
    end
  end

  // Register file as seen through the DUT's write port
  always @(posedge clock) begin
    if (resetN && isWrite) dut_rf[A3] <= writeData;
  end

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    if (resetN) begin
      int g;
      logic [NR-1:0] m;
      g = pick();
      m = '0;
      for (int r = 0; r < int'(NR); r++) begin
        if ((mv[0] && maddr[0] == AW'(r)) || (mv[1] && maddr[1] == AW'(r)) ||
            (exp_we && exp_a3 == AW'(r))) m[r] = 1'b1;
      end
      chk("aluReady", 64'(aluReady), 64'(!mv[0] || g == 0));
      chk("ldReady", 64'(ldReady), 64'(!mv[1] || g == 1));
      chk("isWrite", 64'(isWrite), 64'(exp_we));
      if (exp_we) begin
        chk("A3", 64'(A3), 64'(exp_a3));
        chk("writeData", 64'(writeData), 64'(exp_wd));
      end
      chk("pendingMask", 64'(pendingMask), 64'(m));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    aluValid = 1'b0;
    ldValid  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < int'(NR); i++) begin
      ref_rf[i] = '0;
      dut_rf[i] = '0;
    end

    // Reset state, no clock edge needed
    #1;
    chk("rst_isWrite", 64'(isWrite), 64'd0);
    chk("rst_A3", 64'(A3), 64'd0);
    chk("rst_mask", 64'(pendingMask), 64'd0);
    chk("rst_aluReady", 64'(aluReady), 64'd1);
    chk("rst_ldReady", 64'(ldReady), 64'd1);
    @(posedge clock);
    #1 resetN = 1'b1;
    step();

    // Single ALU write r4
    aluValid = 1'b1; aluAddr = 4'd4; aluData = 32'h12345678;
    step();
    idle();
    chk("t2_mask_n", 64'(pendingMask), 64'h0010);
    chk("t2_we_n", 64'(isWrite), 64'd0);
    step();
    chk("t2_we", 64'(isWrite), 64'd1);
    chk("t2_a3", 64'(A3), 64'd4);
    chk("t2_wd", 64'(writeData), 64'h12345678);
    chk("t2_mask_n1", 64'(pendingMask), 64'h0010);
    step();
    chk("t2_we_off", 64'(isWrite), 64'd0);
    chk("t2_mask_n2", 64'(pendingMask), 64'h0000);
    chk("t2_rf4", 64'(dut_rf[4]), 64'h12345678);

    // Same-edge ALU/load, rr favours ALU; second load waits for its slot's grant
    aluValid = 1'b1; aluAddr = 4'd1; aluData = 32'hA;
    ldValid  = 1'b1; ldAddr  = 4'd2; ldData  = 32'hB;
    step();
    aluValid = 1'b0;
    ldAddr = 4'd5; ldData = 32'hC;
    chk("t3_mask", 64'(pendingMask), 64'h0006);
    chk("t3_ldReady_busy", 64'(ldReady), 64'd0);
    step();
    chk("t3_a3_alu", 64'(A3), 64'd1);
    chk("t3_wd_alu", 64'(writeData), 64'hA);
    chk("t3_ldReady_grant", 64'(ldReady), 64'd1);
    step();
    ldValid = 1'b0;
    chk("t3_a3_ld", 64'(A3), 64'd2);
    chk("t3_wd_ld", 64'(writeData), 64'hB);
    step();
    chk("t3_a3_ld2", 64'(A3), 64'd5);
    chk("t3_wd_ld2", 64'(writeData), 64'hC);
    step();

    // Load then ALU to the same register: later data survives
    ldValid = 1'b1; ldAddr = 4'd3; ldData = 32'h11;
    step();
    ldValid = 1'b0;
    aluValid = 1'b1; aluAddr = 4'd3; aluData = 32'h22;
    step();
    aluValid = 1'b0;
    chk("t4_wd_first", 64'(writeData), 64'h11);
    step();
    chk("t4_wd_second", 64'(writeData), 64'h22);
    step();
    chk("t4_rf3", 64'(dut_rf[3]), 64'h22);
    chk("t4_ref_rf3", 64'(ref_rf[3]), 64'h22);

    // Age beats the rr pointer: commit order r9, r8, r10, r11
    aluValid = 1'b1; aluAddr = 4'd8; aluData = 32'h1;
    ldValid  = 1'b1; ldAddr  = 4'd9; ldData  = 32'h2;
    step();
    aluValid = 1'b0;
    ldAddr = 4'd10; ldData = 32'h3;
    step();
    chk("t4b_a3_0", 64'(A3), 64'd9);
    ldValid = 1'b0;
    aluValid = 1'b1; aluAddr = 4'd11; aluData = 32'h4;
    step();
    aluValid = 1'b0;
    chk("t4b_a3_1", 64'(A3), 64'd8);
    step();
    chk("t4b_a3_2", 64'(A3), 64'd10);
    step();
    chk("t4b_a3_3", 64'(A3), 64'd11);
    chk("t4b_wd_3", 64'(writeData), 64'h4);
    step();

    // Back-to-back ALU stream r0..r7
    for (int i = 0; i < 8; i++) begin
      aluValid = 1'b1; aluAddr = AW'(i); aluData = 32'h100 + DW'(i);
      chk($sformatf("t5_ready_%0d", i), 64'(aluReady), 64'd1);
      step();
      if (i > 0) begin
        chk($sformatf("t5_we_%0d", i), 64'(isWrite), 64'd1);
        chk($sformatf("t5_a3_%0d", i), 64'(A3), 64'(i - 1));
      end
    end
    aluValid = 1'b0;
    step();
    chk("t5_we_last", 64'(isWrite), 64'd1);
    chk("t5_a3_last", 64'(A3), 64'd7);
    step();
    step();
    chk("t5_rf7", 64'(dut_rf[7]), 64'h107);

    // Mid-cycle reset with both slots full and a write on the port
    aluValid = 1'b1; aluAddr = 4'd12; aluData = 32'hC0;
    ldValid  = 1'b1; ldAddr  = 4'd13; ldData  = 32'hD0;
    step();
    ldValid = 1'b0;
    aluAddr = 4'd14; aluData = 32'hE0;
    step();
    aluValid = 1'b0;
    chk("t6_we_before", 64'(isWrite), 64'd1);
    chk("t6_a3_before", 64'(A3), 64'd12);
    chk("t6_mask_before", 64'(pendingMask), 64'h7000);
    #2 resetN = 1'b0;
    #1;
    chk("t6_we_rst", 64'(isWrite), 64'd0);
    chk("t6_mask_rst", 64'(pendingMask), 64'h0000);
    chk("t6_aluReady_rst", 64'(aluReady), 64'd1);
    chk("t6_ldReady_rst", 64'(ldReady), 64'd1);
    @(posedge clock);
    #1 resetN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t6_no_stale_%0d", i), 64'(isWrite), 64'd0);
    end
    chk("t6_rf12", 64'(dut_rf[12]), 64'd0);
    chk("t6_rf13", 64'(dut_rf[13]), 64'd0);
    chk("t6_rf14", 64'(dut_rf[14]), 64'd0);

    // Final register file agrees with the model's commit history
    for (int i = 0; i < int'(NR); i++) begin
      chk($sformatf("rf_r%0d", i), 64'(dut_rf[i]), 64'(ref_rf[i]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
